// File: rtl/spi_pin_ctrl_pkg.sv
// Shared definitions for the SPI pin controller.
// Contents: command opcodes, FSM state encoding, status byte layout,
// and the command reject rule.
package spi_pin_ctrl_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_TOGGLE     = 8'h01;
    localparam logic [7:0] OP_SET        = 8'h02;
    localparam logic [7:0] OP_CLEAR      = 8'h03;
    localparam logic [7:0] OP_READ       = 8'h04;
    localparam logic [7:0] OP_TOGGLE_ALL = 8'h05;

    localparam int STATUS_ERR_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPCODE,
        ST_INDEX,
        ST_EXEC
    } state_t;

    // The full 8-bit index is compared, so out-of-range indices never wrap.
    function automatic logic cmd_reject(input logic [7:0] op, input logic [7:0] idx,
                                        input int num_pins);
        case (op)
            OP_NOP, OP_TOGGLE_ALL:                return 1'b0;
            OP_TOGGLE, OP_SET, OP_CLEAR, OP_READ: return int'(idx) >= num_pins;
            default:                              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_shift.sv
// SPI front end in the system clock domain.
// Synchronises SCLK/CS/MOSI, derives edge strobes, and holds the RX and TX
// shift registers.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   sclk, cs, mosi      raw asynchronous SPI inputs
//   tx_load, tx_data    response byte for the next byte slot
//   cs_fall, cs_rise    synced chip-select edge strobes
//   byte_done, rx_byte  strobe and value when the 8th bit of a byte is sampled
//   miso                current TX bit
module spi_sync_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    input  logic       tx_load,
    input  logic [7:0] tx_data,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       miso
);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_q, cs_q;
    logic       sclk_rise, sclk_fall;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift, tx_hold;
    logic       tx_pending;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise & ~cs_s & (bit_cnt == 3'd7);
    assign miso      = tx_shift[7];

    // CS synchroniser resets to 0: a frame can only open after CS has been
    // observed high, even if CS is held low through reset.
    // A load coinciding with the CS fall presets the first byte directly;
    // any other load waits for the next SCLK fall, which is the edge that
    // presents the following byte's MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            cs_sync    <= '0;
            mosi_sync  <= '0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            tx_pending <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            if (cs_fall || cs_rise) begin
                bit_cnt    <= '0;
                rx_shift   <= '0;
                tx_pending <= 1'b0;
                tx_shift   <= (cs_fall && tx_load) ? tx_data : 8'h00;
            end else if (!cs_s) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (sclk_fall) begin
                    tx_shift   <= tx_pending ? tx_hold : {tx_shift[6:0], 1'b0};
                    tx_pending <= 1'b0;
                end
                if (tx_load) begin
                    tx_hold    <= tx_data;
                    tx_pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_pin_ctrl.sv
// SPI-controlled pin register: set/clear/toggle/read single pins or toggle all.
// Ports:
//   CLK, RST_N       system clock, synchronous active-low reset
//   SCLK, CS, MOSI   SPI mode-0 inputs (asynchronous)
//   MISO             echo/readback/status byte, 0 outside a frame
//   pins             pin state register
//   cmd_valid        one-cycle pulse per executed command
//   cmd_err          one-cycle pulse per rejected command
//
// state     | meaning
// ST_IDLE   | CS high or frame aborted; waiting for CS fall
// ST_OPCODE | receiving opcode byte of a pair
// ST_INDEX  | receiving index byte of a pair
// ST_EXEC   | apply command, pulse cmd_valid/cmd_err
import spi_pin_ctrl_pkg::*;

module spi_pin_ctrl #(
    parameter int NUM_PINS    = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                SCLK,
    input  logic                CS,
    input  logic                MOSI,
    output logic                MISO,
    output logic [NUM_PINS-1:0] pins,
    output logic                cmd_valid,
    output logic                cmd_err
);

    logic                cs_fall, cs_rise, byte_done;
    logic [7:0]          rx_byte;
    logic                tx_load;
    logic [7:0]          tx_data;
    state_t              state;
    logic [7:0]          opcode;
    logic [NUM_PINS-1:0] exec_mask;
    logic [NUM_PINS-1:0] rx_mask;
    logic                rej, new_rej;
    logic                err;
    logic                first_byte;

    spi_sync_shift #(.SYNC_STAGES(SYNC_STAGES)) u_sync_shift (
        .clk       (CLK),
        .rst_n     (RST_N),
        .sclk      (SCLK),
        .cs        (CS),
        .mosi      (MOSI),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .miso      (MISO)
    );

    // Out-of-range indices shift the one-hot mask to zero; they are rejected anyway.
    assign rx_mask = NUM_PINS'(1) << rx_byte;
    assign new_rej = cmd_reject(opcode, rx_byte, NUM_PINS);

    // Response for the next byte slot. READ readback is taken when the index
    // arrives; READ never modifies pins so it matches the post-exec value.
    always_comb begin
        tx_load = 1'b0;
        tx_data = 8'h00;
        if (state == ST_IDLE && cs_fall) begin
            tx_load                 = 1'b1;
            tx_data[STATUS_ERR_BIT] = err;
        end else if (byte_done && state == ST_OPCODE) begin
            tx_load = 1'b1;
            tx_data = rx_byte;
        end else if (byte_done && state == ST_INDEX) begin
            tx_load = 1'b1;
            if (opcode == OP_READ)
                tx_data = new_rej ? 8'hFF : {7'b0, |(pins & rx_mask)};
            else
                tx_data = rx_byte;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            pins       <= '0;
            cmd_valid  <= 1'b0;
            cmd_err    <= 1'b0;
            err        <= 1'b0;
            opcode     <= OP_NOP;
            exec_mask  <= '0;
            rej        <= 1'b0;
            first_byte <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state      <= ST_OPCODE;
                        first_byte <= 1'b1;
                    end
                end
                ST_OPCODE: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (byte_done) begin
                        opcode <= rx_byte;
                        state  <= ST_INDEX;
                        // the status byte has now been fully clocked out
                        if (first_byte) begin
                            err        <= 1'b0;
                            first_byte <= 1'b0;
                        end
                    end
                end
                ST_INDEX: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (byte_done) begin
                        exec_mask <= rx_mask;
                        rej       <= new_rej;
                        state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (rej) begin
                        cmd_err <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        cmd_valid <= 1'b1;
                        case (opcode)
                            OP_TOGGLE:     pins <= pins ^ exec_mask;
                            OP_SET:        pins <= pins | exec_mask;
                            OP_CLEAR:      pins <= pins & ~exec_mask;
                            OP_TOGGLE_ALL: pins <= ~pins;
                            default:       ;
                        endcase
                    end
                    state <= cs_rise ? ST_IDLE : ST_OPCODE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
